// File: rtl/ram_fifo_ctrl_if.sv
// Handshake and RAM-port bundle for ram_fifo_ctrl.
// The master modport is the controller side; slave is the producer/consumer/RAM side.
interface ram_fifo_ctrl_if #(
    parameter int XLEN      = 32,
    parameter int ENTRY_NUM = 32
);
    localparam int AWDTH = $clog2(ENTRY_NUM);

    logic             push_valid_i;
    logic             push_ready_o;
    logic [XLEN-1:0]  push_data_i;
    logic             pop_valid_o;
    logic             pop_ready_i;
    logic [XLEN-1:0]  pop_data_o;
    logic [AWDTH:0]   count_o;
    logic             ram_we_o;
    logic [AWDTH-1:0] ram_waddr_o;
    logic [XLEN-1:0]  ram_wdata_o;
    logic [AWDTH-1:0] ram_raddr_o;
    logic [XLEN-1:0]  ram_rdata_i;

    modport master (
        input  push_valid_i, push_data_i, pop_ready_i, ram_rdata_i,
        output push_ready_o, pop_valid_o, pop_data_o, count_o,
               ram_we_o, ram_waddr_o, ram_wdata_o, ram_raddr_o
    );

    modport slave (
        output push_valid_i, push_data_i, pop_ready_i, ram_rdata_i,
        input  push_ready_o, pop_valid_o, pop_data_o, count_o,
               ram_we_o, ram_waddr_o, ram_wdata_o, ram_raddr_o
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FWFT queue controller over an async-read/sync-write RAM with a registered head stage.
// Latency: push at edge N is visible on pop side after edge N+1; 1 push + 1 pop per cycle.
// Backpressure: push_ready_o drops when the RAM holds ENTRY_NUM words; the head adds one more slot.
module ram_fifo_ctrl #(
    parameter int XLEN      = 32,
    parameter int ENTRY_NUM = 32,
    parameter int AWDTH     = $clog2(ENTRY_NUM)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    ram_fifo_ctrl_if.master bus
);
    localparam logic [AWDTH:0] FULL_CNT = (AWDTH+1)'(ENTRY_NUM);

    logic [AWDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWDTH:0]   ram_cnt_q, ram_cnt_d;
    logic             head_vld_q, head_vld_d;
    logic [XLEN-1:0]  head_data_q, head_data_d;

    logic push_ready;
    logic push_fire;
    logic pop_fire;
    logic load;

    // Ready looks only at registered RAM occupancy, so pop_ready_i never reaches it.
    assign push_ready = !rst_i && (ram_cnt_q != FULL_CNT);
    assign push_fire  = bus.push_valid_i && push_ready && !flush_i;
    assign pop_fire   = head_vld_q && bus.pop_ready_i && !flush_i;
    assign load       = (ram_cnt_q != '0) && (!head_vld_q || pop_fire) && !flush_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_cnt_d   = ram_cnt_q;
        head_vld_d  = head_vld_q;
        head_data_d = head_data_q;

        if (push_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (load) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            head_data_d = bus.ram_rdata_i;
            head_vld_d  = 1'b1;
        end else if (pop_fire) begin
            head_vld_d  = 1'b0;
        end

        if (push_fire && !load) begin
            ram_cnt_d = ram_cnt_q + 1'b1;
        end else if (load && !push_fire) begin
            ram_cnt_d = ram_cnt_q - 1'b1;
        end

        // Flush drops queue state but leaves the stale head data in place.
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            ram_cnt_d  = '0;
            head_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            head_vld_q  <= 1'b0;
            head_data_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            head_vld_q  <= head_vld_d;
            head_data_q <= head_data_d;
        end
    end

    assign bus.push_ready_o = push_ready;
    assign bus.pop_valid_o  = head_vld_q;
    assign bus.pop_data_o   = head_data_q;
    assign bus.count_o      = ram_cnt_q + (AWDTH+1)'(head_vld_q);
    assign bus.ram_we_o     = push_fire;
    assign bus.ram_waddr_o  = wr_ptr_q;
    assign bus.ram_wdata_o  = bus.push_data_i;
    assign bus.ram_raddr_o  = rd_ptr_q;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomized bench for ram_fifo_ctrl against a queue model; includes a 32x32 RAM.
// Directed sequences cover first-word latency, full, full+pop, flush and mid-stream reset.
module tb_ram_fifo_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.XLEN(32), .ENTRY_NUM(32)) bus ();

    ram_fifo_ctrl #(.XLEN(32), .ENTRY_NUM(32)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (bus.ram_we_o) mem[bus.ram_waddr_o] <= bus.ram_wdata_o;
    end
    assign bus.ram_rdata_i = mem[bus.ram_raddr_o];

    int checks = 0;
    int errors = 0;

    // Model: every word held by the controller in order; hv says whether the front is visible.
    logic [31:0] q[$];
    bit          hv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle: set inputs, check mid-cycle, advance the model on the edge.
    task automatic step(input bit pv, input logic [31:0] pd, input bit pr, input bit fl, input bit r);
        int  in_ram;
        bit  exp_rdy, exp_push, exp_pop;
        rst               = r;
        flush             = fl;
        bus.push_valid_i  = pv;
        bus.push_data_i   = pd;
        bus.pop_ready_i   = pr;
        @(negedge clk);
        in_ram   = q.size() - int'(hv);
        exp_rdy  = !r && (in_ram < 32);
        exp_push = pv && exp_rdy && !fl;
        exp_pop  = hv && pr && !fl;
        chk("push_ready", 32'(bus.push_ready_o), 32'(exp_rdy));
        chk("pop_valid", 32'(bus.pop_valid_o), 32'(hv));
        if (hv) chk("pop_data", bus.pop_data_o, q[0]);
        chk("count", 32'(bus.count_o), 32'(q.size()));
        chk("ram_we", 32'(bus.ram_we_o), 32'(exp_push));
        chk("count_max", 32'(bus.count_o <= 6'd33), 32'd1);
        @(posedge clk);
        if (r || fl) begin
            q.delete();
            hv = 1'b0;
        end else begin
            if (exp_pop) void'(q.pop_front());
            if (exp_push) q.push_back(pd);
            hv = (hv && !exp_pop) || (in_ram != 0);
        end
        #1;
    endtask

    task automatic rnd_steps(input int n, input int pv_pct, input int pr_pct);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 99) < pv_pct, $urandom, $urandom_range(0, 99) < pr_pct, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst              = 1'b1;
        flush            = 1'b0;
        bus.push_valid_i = 1'b1;
        bus.push_data_i  = 32'hDEAD_BEEF;
        bus.pop_ready_i  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pop_valid", 32'(bus.pop_valid_o), 32'd0);
        chk("rst_pop_data", bus.pop_data_o, 32'd0);
        chk("rst_count", 32'(bus.count_o), 32'd0);
        chk("rst_ram_we", 32'(bus.ram_we_o), 32'd0);
        chk("rst_push_ready", 32'(bus.push_ready_o), 32'd0);
        q.delete();
        hv = 1'b0;

        // Single word latency
        step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
        chk("t1_count_e1", 32'(bus.count_o), 32'd1);
        chk("t1_valid_e1", 32'(bus.pop_valid_o), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t1_count_e2", 32'(bus.count_o), 32'd1);
        chk("t1_valid_e2", 32'(bus.pop_valid_o), 32'd1);
        chk("t1_data_e2", bus.pop_data_o, 32'hA5A5_0001);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Fill to capacity, then over-push
        for (int i = 0; i < 36; i++) step(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0);
        chk("full_count", 32'(bus.count_o), 32'd33);
        chk("full_ready", 32'(bus.push_ready_o), 32'd0);
        step(1'b1, 32'hBAD0_0001, 1'b0, 1'b0, 1'b0);

        // Full plus pop: no push this cycle, push accepted next cycle
        step(1'b1, 32'h2000_0001, 1'b1, 1'b0, 1'b0);
        chk("fullpop_count1", 32'(bus.count_o), 32'd32);
        step(1'b1, 32'h2000_0002, 1'b1, 1'b0, 1'b0);
        chk("fullpop_count2", 32'(bus.count_o), 32'd32);

        // Random traffic across several pointer wraps
        rnd_steps(150, 75, 60);
        rnd_steps(100, 90, 30);
        rnd_steps(150, 60, 80);

        // Flush with 10 words queued
        repeat (40) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 32'h3000 + 32'(i), 1'b0, 1'b0, 1'b0);
        chk("pre_flush_count", 32'(bus.count_o), 32'd10);
        step(1'b1, 32'hBAD0_0002, 1'b1, 1'b1, 1'b0);
        chk("flush_count", 32'(bus.count_o), 32'd0);
        chk("flush_valid", 32'(bus.pop_valid_o), 32'd0);
        rnd_steps(60, 70, 60);

        // Mid-stream reset
        rnd_steps(20, 90, 20);
        step(1'b1, 32'hBAD0_0003, 1'b1, 1'b0, 1'b1);
        chk("mrst_count", 32'(bus.count_o), 32'd0);
        chk("mrst_valid", 32'(bus.pop_valid_o), 32'd0);
        chk("mrst_data", bus.pop_data_o, 32'd0);
        step(1'b1, 32'h4000_0001, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("mrst_first", bus.pop_data_o, 32'h4000_0001);
        rnd_steps(60, 60, 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
